boxing_round_ctrl: RTL and testbench
====================================

Name: boxing_round_ctrl

Overview:
- Game sequencer that sits directly upstream of the 5-LED display driver.
- Produces the 2-bit display mode (`state`) and the 0..4 display step (`step`) that the driver decodes into LED patterns.
- Takes the start and punch buttons, times each phase with a prescaled tick, judges punch timing, and tallies hits until a knockout or until the rounds run out.

Parameters:
- TICK_DIV, 12500000, clk cycles per game tick (0.25 s at 50 MHz); minimum 2.
- HIT_POS, 4, sweep step at which a punch counts as a hit (0..4).
- HOLD_TICKS, 4, ticks the result/health display is held between rounds.
- MAX_ROUNDS, 8, rounds allowed before the game ends without KO (1..15).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset.
- start  in  1  raw start button, active-high, asynchronous to clk.
- punch  in  1  raw punch button, active-high, asynchronous to clk.
- state  out  2  display mode: 00 IDLE, 10 CHARGE, 11 SWEEP, 01 HEALTH.
- step  out  3  display step, always 0..4.
- hits  out  3  hits landed this game, 0..4.
- done  out  1  high when the game is over; holds until a new start.
- ko  out  1  high with done when hits reached 4.

Behaviour:
- Reset (rst=0, async):
  - state=00, step=0, hits=0, done=0, ko=0.
  - Round counter, prescaler and synchronizers cleared.
  - Reset is allowed mid-phase and returns to IDLE within the same cycle.
- Button inputs:
  - Each button goes through a 2-flop synchronizer, then a rising-edge detector.
  - `start_e`/`punch_e` are 1-cycle pulses 3 clk after the raw rise.
  - A held button produces no further pulses.
- Prescaler:
  - Counts 0..TICK_DIV-1; `tick` pulses when the count wraps.
  - Cleared to 0 on every state transition, so each phase starts with a full tick period.
- IDLE (00):
  - step=0.
  - On `start_e`: clear hits, rounds, done and ko, then go to CHARGE with step=0.
  - Punch is ignored.
- CHARGE (10):
  - On tick: if step<4, step++.
  - If step==4 on tick: go to SWEEP with step=0.
  - Punch and start are ignored.
- SWEEP (11):
  - On `punch_e`, judged against the current step, before any same-cycle tick:
    - step==HIT_POS: hit, hits++ (saturates at 4).
    - Otherwise: miss.
    - Either way go to HEALTH.
  - Else on tick: if step<4, step++; if step==4, miss and go to HEALTH.
  - Every exit from SWEEP increments rounds.
- HEALTH (01):
  - step=hits.
  - Counts HOLD_TICKS ticks, then:
    - hits==4: set done=1, ko=1 and stay in HEALTH.
    - rounds==MAX_ROUNDS: set done=1, ko=0 and stay in HEALTH.
    - Otherwise: go to CHARGE with step=0.
  - While done=1: `start_e` goes to IDLE; the clears happen on the following start from IDLE.
  - While done=0: start is ignored.
- General:
  - Outputs are registered; a state and step change is visible 1 clk after the triggering tick or edge.
  - step is never >4 and hits is never >4.
  - A punch and a start in the same cycle are each judged only in their own valid state.

Test Plan (TICK_DIV=4, HOLD_TICKS=2, MAX_ROUNDS=2, HIT_POS=4):
- Reset then idle:
  - Stimulus: assert rst=0 mid-SWEEP; release.
  - Required: state=00, step=0, hits=0, done=0 immediately; stays IDLE with no start.
- Charge timing:
  - Stimulus: start pulse.
  - Required: state=10; step goes 0,1,2,3,4 at 4-clk spacing; then state=11, step=0.
- Hit:
  - Stimulus: punch timed so `punch_e` lands while step==4 in SWEEP.
  - Required: hits=1, state=01, step=1; after 8 clk, state=10, step=0.
- Miss:
  - Stimulus (a): punch `punch_e` at step==2.
  - Stimulus (b): no punch.
  - Required for (a): state=01, hits unchanged.
  - Required for (b): HEALTH entered one tick after step reaches 4.
- Game over, no KO:
  - Stimulus: two rounds, both missed.
  - Required: done=1, ko=0, state=01, step=0; start → IDLE; second start → hits=0, done=0.
- Edge cases:
  - Stimulus (a): punch edge on the same cycle as a tick at step==4.
  - Stimulus (b): held punch.
  - Stimulus (c): punch in CHARGE.
  - Required for (a): counts as hit.
  - Required for (b): only one judgement.
  - Required for (c): no effect.

Source files
------------

// File: rtl/boxing_round_ctrl.sv
// Boxing-game round sequencer: synchronises the start/punch buttons, times each phase
// with a prescaled tick, judges punch timing and drives mode/step for the 5-LED display.
module boxing_round_ctrl #(
  parameter int unsigned TICK_DIV   = 12500000,
  parameter int unsigned HIT_POS    = 4,
  parameter int unsigned HOLD_TICKS = 4,
  parameter int unsigned MAX_ROUNDS = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       punch,
  output logic [1:0] state,
  output logic [2:0] step,
  output logic [2:0] hits,
  output logic       done,
  output logic       ko
);

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] CHARGE = 2'b10;
  localparam logic [1:0] SWEEP  = 2'b11;
  localparam logic [1:0] HEALTH = 2'b01;

  localparam int CNT_W  = $clog2(TICK_DIV);
  localparam int HOLD_W = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

  localparam logic [CNT_W-1:0]  TICK_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_TICKS - 1);
  localparam logic [2:0]        HIT_STEP  = 3'(HIT_POS);
  localparam logic [3:0]        LAST_RND  = 4'(MAX_ROUNDS);
  localparam logic [2:0]        TOP_STEP  = 3'd4;

  logic [2:0]        startSync_q;
  logic [2:0]        punchSync_q;
  logic              startE_q;
  logic              punchE_q;

  logic [1:0]        state_q, state_d;
  logic [2:0]        step_q, step_d;
  logic [2:0]        hits_q, hits_d;
  logic [3:0]        rounds_q, rounds_d;
  logic              done_q, done_d;
  logic              ko_q, ko_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [CNT_W-1:0]  tickCnt_q, tickCnt_d;

  logic              tick;
  logic [2:0]        hitsInc;

  // Two flops of synchronisation, the third flop only remembers the previous level
  // so the edge pulse is registered and lands 3 clk after the raw rise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      startSync_q <= '0;
      punchSync_q <= '0;
      startE_q    <= 1'b0;
      punchE_q    <= 1'b0;
    end else begin
      startSync_q <= {startSync_q[1:0], start};
      punchSync_q <= {punchSync_q[1:0], punch};
      startE_q    <= startSync_q[1] & ~startSync_q[2];
      punchE_q    <= punchSync_q[1] & ~punchSync_q[2];
    end
  end

  assign tick    = (tickCnt_q == TICK_LAST);
  assign hitsInc = (hits_q == TOP_STEP) ? hits_q : hits_q + 3'd1;

  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    hits_d   = hits_q;
    rounds_d = rounds_q;
    done_d   = done_q;
    ko_d     = ko_q;
    hold_d   = hold_q;
    case (state_q)
      IDLE: begin
        step_d = 3'd0;
        if (startE_q) begin
          hits_d   = 3'd0;
          rounds_d = 4'd0;
          done_d   = 1'b0;
          ko_d     = 1'b0;
          state_d  = CHARGE;
        end
      end
      CHARGE: begin
        if (tick) begin
          if (step_q < TOP_STEP) begin
            step_d = step_q + 3'd1;
          end else begin
            state_d = SWEEP;
            step_d  = 3'd0;
          end
        end
      end
      SWEEP: begin
        // A punch is judged before a tick arriving in the same cycle.
        if (punchE_q) begin
          state_d  = HEALTH;
          rounds_d = rounds_q + 4'd1;
          hold_d   = '0;
          if (step_q == HIT_STEP) begin
            hits_d = hitsInc;
            step_d = hitsInc;
          end else begin
            step_d = hits_q;
          end
        end else if (tick) begin
          if (step_q < TOP_STEP) begin
            step_d = step_q + 3'd1;
          end else begin
            state_d  = HEALTH;
            rounds_d = rounds_q + 4'd1;
            hold_d   = '0;
            step_d   = hits_q;
          end
        end
      end
      HEALTH: begin
        step_d = hits_q;
        if (done_q) begin
          if (startE_q) begin
            state_d = IDLE;
            step_d  = 3'd0;
          end
        end else if (tick) begin
          if (hold_q == HOLD_LAST) begin
            if (hits_q == TOP_STEP) begin
              done_d = 1'b1;
              ko_d   = 1'b1;
            end else if (rounds_q == LAST_RND) begin
              done_d = 1'b1;
              ko_d   = 1'b0;
            end else begin
              state_d = CHARGE;
              step_d  = 3'd0;
            end
          end else begin
            hold_d = hold_q + HOLD_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        step_d  = 3'd0;
      end
    endcase
  end

  // Restarting the prescaler on every transition gives each phase a full first tick.
  always_comb begin
    tickCnt_d = tickCnt_q + CNT_W'(1);
    if ((state_d != state_q) || tick) begin
      tickCnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      step_q    <= 3'd0;
      hits_q    <= 3'd0;
      rounds_q  <= 4'd0;
      done_q    <= 1'b0;
      ko_q      <= 1'b0;
      hold_q    <= '0;
      tickCnt_q <= '0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      hits_q    <= hits_d;
      rounds_q  <= rounds_d;
      done_q    <= done_d;
      ko_q      <= ko_d;
      hold_q    <= hold_d;
      tickCnt_q <= tickCnt_d;
    end
  end

  assign state = state_q;
  assign step  = step_q;
  assign hits  = hits_q;
  assign done  = done_q;
  assign ko    = ko_q;

endmodule

// File: tb/tb_boxing_round_ctrl.sv
// Directed bench for boxing_round_ctrl with a short tick (4 clk), 2-tick hold and 2 rounds.
module tb_boxing_round_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic       punch;
  logic [1:0] state;
  logic [2:0] step;
  logic [2:0] hits;
  logic       done;
  logic       ko;

  int testsRun;
  int failCount;

  boxing_round_ctrl #(
    .TICK_DIV  (4),
    .HIT_POS   (4),
    .HOLD_TICKS(2),
    .MAX_ROUNDS(2)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .punch(punch),
    .state(state),
    .step (step),
    .hits (hits),
    .done (done),
    .ko   (ko)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so a stuck design still ends the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One-cycle press of a raw button, driven and released on negedges.
  task automatic applyStimulus(input bit isPunch);
    if (isPunch) punch = 1'b1; else start = 1'b1;
    waitCycles(1);
    if (isPunch) punch = 1'b0; else start = 1'b0;
  endtask

  task automatic checkPhase(input string tag, input logic [1:0] expState, input logic [2:0] expStep);
    checkOutput({tag, "_state"}, 32'(state), 32'(expState));
    checkOutput({tag, "_step"}, 32'(step), 32'(expStep));
  endtask

  // Start latency: raw rise -> start_e after 3 clk -> CHARGE on the 4th edge.
  task automatic startGame(input string tag);
    applyStimulus(1'b0);
    waitCycles(3);
    checkPhase(tag, 2'b10, 3'd0);
    checkOutput({tag, "_hits"}, 32'(hits), 0);
    checkOutput({tag, "_done"}, 32'(done), 0);
    checkOutput({tag, "_ko"}, 32'(ko), 0);
  endtask

  task automatic runCharge(input string tag);
    for (int k = 1; k <= 4; k++) begin
      waitCycles(4);
      checkPhase($sformatf("%s_c%0d", tag, k), 2'b10, 3'(k));
    end
    waitCycles(4);
    checkPhase({tag, "_sweep"}, 2'b11, 3'd0);
  endtask

  initial begin
    testsRun  = 0;
    failCount = 0;
    rst   = 1'b0;
    start = 1'b0;
    punch = 1'b0;
    waitCycles(3);
    checkPhase("por", 2'b00, 3'd0);
    checkOutput("por_hits", 32'(hits), 0);
    checkOutput("por_done", 32'(done), 0);
    checkOutput("por_ko", 32'(ko), 0);
    rst = 1'b1;
    waitCycles(2);

    // Reset asserted mid-SWEEP must return to IDLE without a clock edge.
    startGame("g0");
    runCharge("g0");
    waitCycles(5);
    rst = 1'b0;
    #1;
    checkPhase("rstmid", 2'b00, 3'd0);
    checkOutput("rstmid_hits", 32'(hits), 0);
    checkOutput("rstmid_done", 32'(done), 0);
    waitCycles(2);
    rst = 1'b1;
    waitCycles(20);
    checkPhase("idle_hold", 2'b00, 3'd0);

    // Game A: hit in round 1, punch during CHARGE ignored, miss at step 2 in round 2.
    startGame("gA");
    runCharge("gA");
    waitCycles(14);
    applyStimulus(1'b1);
    waitCycles(3);
    checkPhase("hit", 2'b01, 3'd1);
    checkOutput("hit_hits", 32'(hits), 1);
    checkOutput("hit_done", 32'(done), 0);
    waitCycles(7);
    checkOutput("hold_state", 32'(state), 32'(2'b01));
    waitCycles(1);
    checkPhase("hold_end", 2'b10, 3'd0);
    waitCycles(2);
    applyStimulus(1'b1);
    waitCycles(5);
    checkPhase("chg_punch", 2'b10, 3'd2);
    checkOutput("chg_punch_hits", 32'(hits), 1);
    waitCycles(12);
    checkPhase("gA_sweep2", 2'b11, 3'd0);
    waitCycles(6);
    applyStimulus(1'b1);
    waitCycles(3);
    checkPhase("miss_a", 2'b01, 3'd1);
    checkOutput("miss_a_hits", 32'(hits), 1);
    waitCycles(1);
    applyStimulus(1'b0);
    waitCycles(5);
    checkOutput("start_ign_state", 32'(state), 32'(2'b01));
    checkOutput("start_ign_done", 32'(done), 0);
    waitCycles(1);
    checkPhase("gA_over", 2'b01, 3'd1);
    checkOutput("gA_over_done", 32'(done), 1);
    checkOutput("gA_over_ko", 32'(ko), 0);
    applyStimulus(1'b0);
    waitCycles(3);
    checkPhase("gA_idle", 2'b00, 3'd0);
    checkOutput("gA_idle_done", 32'(done), 1);

    // Game B: two rounds with no punch, game ends without KO.
    startGame("gB");
    runCharge("gB");
    waitCycles(19);
    checkPhase("miss_b_pre", 2'b11, 3'd4);
    waitCycles(1);
    checkPhase("miss_b", 2'b01, 3'd0);
    checkOutput("miss_b_hits", 32'(hits), 0);
    waitCycles(8);
    checkPhase("gB_r2", 2'b10, 3'd0);
    runCharge("gB2");
    waitCycles(20);
    checkPhase("gB_miss2", 2'b01, 3'd0);
    waitCycles(8);
    checkPhase("gB_over", 2'b01, 3'd0);
    checkOutput("gB_over_done", 32'(done), 1);
    checkOutput("gB_over_ko", 32'(ko), 0);
    applyStimulus(1'b0);
    waitCycles(3);
    checkPhase("gB_idle", 2'b00, 3'd0);

    // Game C: punch edge coincides with the step-4 tick, and the button stays held.
    startGame("gC");
    runCharge("gC");
    waitCycles(16);
    punch = 1'b1;
    waitCycles(4);
    checkPhase("tie_hit", 2'b01, 3'd1);
    checkOutput("tie_hit_hits", 32'(hits), 1);
    waitCycles(8);
    checkPhase("gC_r2", 2'b10, 3'd0);
    runCharge("gC2");
    waitCycles(19);
    checkPhase("held_pre", 2'b11, 3'd4);
    waitCycles(1);
    checkPhase("held_miss", 2'b01, 3'd1);
    checkOutput("held_hits", 32'(hits), 1);
    punch = 1'b0;
    waitCycles(8);
    checkOutput("gC_over_done", 32'(done), 1);
    checkOutput("gC_over_ko", 32'(ko), 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
